// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the router packet transmitter: FSM encoding,
// header field layout and the reserved destination address.
package router_pkt_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_CHECK   = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  // Destination 3 does not exist on the router
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Payload buffer geometry
  localparam int BUF_DEPTH = 64;
  localparam int BUF_AW    = 6;
  localparam int BUF_CW    = 7;

  function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/router_pkt_tx_buf.sv
// 64-entry payload FIFO. Read data is show-ahead: pop_data_o always shows
// the oldest byte so the transmitter can register it on the pop edge.
// A push while full is dropped, even if a pop happens in the same cycle.
module router_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [7:0]        push_data_i,
  input  logic              pop_i,
  output logic [7:0]        pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [BUF_CW-1:0] count_o
);

  logic [7:0]        mem_q [BUF_DEPTH];
  logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_CW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o     = (count_q == BUF_CW'(BUF_DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at 64
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + BUF_AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + BUF_AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + BUF_CW'(1);
      2'b01:   count_d = count_q - BUF_CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router: sends header, buffered payload and a
// running-XOR parity byte, then watches the router err flag for ERR_WIN
// cycles and enforces GAP_CYC idle cycles before the next packet.
// All outputs except tx_active are registered; tx_done/tx_err are decided
// in the last CHECK cycle (so err in that cycle counts) and appear on the
// following edge.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int ERR_WIN = 3,
  parameter int GAP_CYC = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ld_en,
  input  logic [7:0] ld_data,
  output logic       buf_full,
  output logic [6:0] buf_count,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err,
  output logic       start_rej,
  output logic [2:0] dbg_state
);

  localparam logic [7:0] ERR_LAST = 8'(ERR_WIN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_seen_q, err_seen_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_err_q, tx_err_d;
  logic       start_rej_q, start_rej_d;

  logic       accept, xfer, pop_req, buf_pop, buf_empty;
  logic       check_last, gap_last;
  logic [7:0] buf_rd;

  // Handshake: data_out/pkt_valid present a byte; the router takes it on any
  // rising edge where busy=0 during HEADER, PAYLOAD or PARITY, otherwise the
  // byte, pkt_valid and the FSM hold.
  assign accept = (state_q == ST_IDLE) && start && (dest_addr != ADDR_INVALID) &&
                  (payload_len != '0) && (buf_count >= {1'b0, payload_len});
  assign xfer   = !busy && ((state_q == ST_HEADER) || (state_q == ST_PAYLOAD) ||
                            (state_q == ST_PARITY));
  assign pop_req    = xfer && (state_q != ST_PARITY) && (rem_q != '0);
  assign buf_pop    = pop_req && !buf_empty;
  assign check_last = (state_q == ST_CHECK) && (cnt_q == ERR_LAST);
  assign gap_last   = (state_q == ST_GAP) && (cnt_q == GAP_LAST);

  router_tx_buf u_buf (
    .clk_i       (clock),
    .rst_ni      (resetn),
    .push_i      (ld_en),
    .push_data_i (ld_data),
    .pop_i       (buf_pop),
    .pop_data_o  (buf_rd),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_HEADER;
      ST_HEADER,
      ST_PAYLOAD: if (xfer) state_d = (rem_q != '0) ? ST_PAYLOAD : ST_PARITY;
      ST_PARITY:  if (xfer) state_d = ST_CHECK;
      ST_CHECK:   if (check_last) state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:     if (gap_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: byte on the bus, parity, counters, pulses
  always_comb begin
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    parity_d    = parity_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    err_seen_d  = err_seen_q;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    start_rej_d = start && !accept;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d      = make_header(payload_len, dest_addr);
          pkt_valid_d = 1'b1;
          parity_d    = make_header(payload_len, dest_addr);
          rem_d       = payload_len;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (pop_req) begin
          data_d   = buf_rd;
          parity_d = parity_q ^ buf_rd;
          rem_d    = rem_q - 6'd1;
        end else if (xfer) begin
          data_d      = parity_q;
          pkt_valid_d = 1'b0;
        end
      end
      ST_PARITY: begin
        if (xfer) begin
          data_d     = 8'h00;
          cnt_d      = 8'd0;
          err_seen_d = 1'b0;
        end
      end
      ST_CHECK: begin
        err_seen_d = err_seen_q | err;
        cnt_d      = cnt_q + 8'd1;
        if (check_last) begin
          tx_done_d = 1'b1;
          tx_err_d  = err_seen_q | err;
          cnt_d     = 8'd0;
        end
      end
      ST_GAP: cnt_d = cnt_q + 8'd1;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      data_q      <= 8'h00;
      pkt_valid_q <= 1'b0;
      parity_q    <= 8'h00;
      rem_q       <= '0;
      cnt_q       <= '0;
      err_seen_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      start_rej_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      parity_q    <= parity_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      err_seen_q  <= err_seen_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
      start_rej_q <= start_rej_d;
    end
  end

  assign data_out  = data_q;
  assign pkt_valid = pkt_valid_q;
  assign tx_active = (state_q != ST_IDLE);
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;
  assign start_rej = start_rej_q;
  assign dbg_state = state_q;

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter ERR_WIN, default 3, cycles after the parity byte during which router err is sampled.
REQ-002 SHALL have parameter GAP_CYC, default 2, idle cycles enforced between packets.
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 ld_en  input  1  write ld_data into the payload buffer.
REQ-006 ld_data  input  8  payload byte.
REQ-007 buf_full  output  1  buffer holds 64 bytes.
REQ-008 buf_count  output  7  bytes currently buffered, 0..64.
REQ-009 start  input  1  single-cycle request to send one packet.
REQ-010 dest_addr  input  2  destination port 0..2; 3 is invalid.
REQ-011 payload_len  input  6  payload byte count, 1..63.
REQ-012 busy  input  1  router busy; the byte on data_out is held while high.
REQ-013 err  input  1  router parity-error flag.
REQ-014 pkt_valid  output  1  high for header and payload bytes, low for the parity byte.
REQ-015 data_out  output  8  byte to router data_in.
REQ-016 tx_active  output  1  high from the header cycle through the last GAP cycle.
REQ-017 tx_done  output  1  one-cycle pulse at the end of the check window.
REQ-018 tx_err  output  1  valid with tx_done; 1 = err seen in the window.
REQ-019 start_rej  output  1  one-cycle pulse when start is refused.

Function
REQ-020 FSM states SHALL be IDLE, HEADER, PAYLOAD, PARITY, CHECK, GAP.
REQ-021 start SHALL be accepted only in IDLE with dest_addr!=3, payload_len!=0 and buf_count>=payload_len; otherwise start_rej SHALL pulse the next cycle and the state SHALL stay unchanged.
REQ-022 After an accepted start, the next cycle SHALL be HEADER with data_out={payload_len,dest_addr}, pkt_valid=1, and the parity register initialised to the header byte.
REQ-023 A byte SHALL be transferred at every rising edge in HEADER, PAYLOAD or PARITY where busy=0; with busy=1, data_out, pkt_valid, state and the buffer SHALL hold.
REQ-024 On each transfer in HEADER/PAYLOAD with payload remaining, the next buffer byte SHALL be popped onto data_out and XORed into the parity register.
REQ-025 On the transfer of the last payload byte, the block SHALL enter PARITY with pkt_valid=0 and data_out=parity (XOR of header and all payload bytes).
REQ-026 On the parity transfer, the block SHALL enter CHECK with data_out=0 and stay ERR_WIN cycles; err=1 in any CHECK cycle SHALL set tx_err.
REQ-027 tx_done SHALL pulse in the last CHECK cycle; the block SHALL then spend GAP_CYC cycles in GAP and return to IDLE.
REQ-028 Unstalled packet latency SHALL be: header 1 cycle after start, parity at cycle 2+payload_len.
REQ-029 The buffer SHALL be a 64-entry FIFO; ld_en while buf_full SHALL drop the byte; a simultaneous ld_en and pop SHALL leave buf_count unchanged; pointers SHALL wrap modulo 64.
REQ-030 Loading SHALL be allowed in every state.

Reset
REQ-031 On resetn=0 at a clock edge: state=IDLE, pkt_valid=0, data_out=0, tx_active=0, tx_done=0, tx_err=0, start_rej=0, buf_count=0, pointers=0, parity=0.
REQ-032 Reset mid-packet SHALL abort it with no parity byte and no tx_done pulse.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, header field positions (addr [1:0], len [7:2]) and the invalid address constant 2'b11.
REQ-034 The payload FIFO SHALL be the sub-module router_tx_buf (push, pop, full, empty, count).

Verification
REQ-035 Load 0x11,0x22,0x33; start addr=1, len=3, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; tx_done with tx_err=0 four cycles later.
REQ-036 Same packet with busy=1 for 2 cycles in HEADER -> 0x0D held 3 cycles, remaining sequence unchanged.
REQ-037 start with addr=3, len=0, or buf_count=2 with len=5 -> start_rej pulse each time, pkt_valid stays 0.
REQ-038 err=1 in the second CHECK cycle -> tx_done=1 with tx_err=1.
REQ-039 Reset asserted after 2 payload bytes of a 10-byte packet -> next cycle pkt_valid=0, buf_count=0, no tx_done.
REQ-040 Load 65 bytes -> buf_full after the 64th, 65th dropped, buf_count=64.
